mb_io_bus_decoder: RTL and testbench

//  Upstream stage of the IO register slaves. Terminates the MicroBlaze MCS IO bus,

---
 rtl/mb_io_bus_decoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_mb_io_bus_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_io_bus_decoder.sv
// ---------------------------------------------------------------------------
// mb_io_bus_decoder
//
// Terminates the MicroBlaze MCS IO bus and fans accesses out to N_SLAVES
// register windows. Each accepted access produces a one-cycle read or write
// strobe to the selected slave, with a shared 3-bit word address, byte
// enables and write data. The slave's read data and ready are returned to
// the CPU as a one-cycle IO_Ready pulse. Unmapped addresses and slaves that
// never answer complete with an error, so the CPU can never hang.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   IO_*  (inputs)    CPU request: address/read/write strobes, byte address,
//                     byte enables, write data
//   IO_Read_Data      read data to CPU, valid while IO_Ready
//   IO_Ready          one-cycle completion pulse to CPU
//   S_Read_Strobe     per-slave one-cycle read strobe
//   S_Write_Strobe    per-slave one-cycle write strobe
//   S_Address         shared word address (captured IO_Address[4:2])
//   S_Byte_Enable     shared captured byte enables
//   S_Write_Data      shared captured write data
//   S_Read_Data       slave i read data at [32*i +: 32]
//   S_Ready           per-slave ready
//   bus_error         one-cycle pulse on unmapped access or timeout
//   err_count         saturating count of bus_error pulses
// ---------------------------------------------------------------------------
module mb_io_bus_decoder #(
    parameter int          N_SLAVES  = 4,
    parameter int          SEL_BITS  = 2,
    parameter int          SEL_LSB   = 8,
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IO_Addr_Strobe,
    input  logic                   IO_Read_Strobe,
    input  logic                   IO_Write_Strobe,
    input  logic [31:0]            IO_Address,
    input  logic [3:0]             IO_Byte_Enable,
    input  logic [31:0]            IO_Write_Data,
    output logic [31:0]            IO_Read_Data,
    output logic                   IO_Ready,
    output logic [N_SLAVES-1:0]    S_Read_Strobe,
    output logic [N_SLAVES-1:0]    S_Write_Strobe,
    output logic [2:0]             S_Address,
    output logic [3:0]             S_Byte_Enable,
    output logic [31:0]            S_Write_Data,
    input  logic [32*N_SLAVES-1:0] S_Read_Data,
    input  logic [N_SLAVES-1:0]    S_Ready,
    output logic                   bus_error,
    output logic [7:0]             err_count
);

    localparam int UP_LSB = SEL_LSB + SEL_BITS;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    // Registered state and outputs
    state_t                r_state;
    logic                  r_is_read;
    logic [SEL_BITS-1:0]   r_sel;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_resp_data;
    logic                  r_io_ready;
    logic [31:0]           r_io_rdata;
    logic [N_SLAVES-1:0]   r_s_rd_stb;
    logic [N_SLAVES-1:0]   r_s_wr_stb;
    logic [2:0]            r_s_addr;
    logic [3:0]            r_s_be;
    logic [31:0]           r_s_wdata;
    logic                  r_bus_error;
    logic [7:0]            r_err_count;

    // Next-state values
    state_t                w_state;
    logic                  w_is_read;
    logic [SEL_BITS-1:0]   w_sel;
    logic                  w_err;
    logic [CNT_W-1:0]      w_cnt;
    logic [31:0]           w_resp_data;
    logic                  w_io_ready;
    logic [31:0]           w_io_rdata;
    logic [N_SLAVES-1:0]   w_s_rd_stb;
    logic [N_SLAVES-1:0]   w_s_wr_stb;
    logic [2:0]            w_s_addr;
    logic [3:0]            w_s_be;
    logic [31:0]           w_s_wdata;
    logic                  w_bus_error;
    logic [7:0]            w_err_count;

    // Address decode of the incoming CPU request
    logic [SEL_BITS-1:0]   w_cpu_sel;
    logic [31:0]           w_cpu_sel_ext;
    logic                  w_mapped;
    logic                  w_request;
    logic [N_SLAVES-1:0]   w_onehot;
    logic                  w_slave_ready;
    logic [31:0]           w_slave_rdata;
    logic                  w_unused_addr_bits;

    assign w_cpu_sel     = IO_Address[SEL_LSB +: SEL_BITS];
    assign w_cpu_sel_ext = {{(32-SEL_BITS){1'b0}}, w_cpu_sel};
    assign w_mapped      = (IO_Address[31:UP_LSB] == BASE_ADDR[31:UP_LSB]) &&
                           (w_cpu_sel_ext < 32'(N_SLAVES));
    assign w_request     = IO_Addr_Strobe && (IO_Read_Strobe || IO_Write_Strobe);
    assign w_onehot      = N_SLAVES'(1) << w_cpu_sel;

    // Byte-offset and in-window bits above the word address do not take part
    // in decoding.
    assign w_unused_addr_bits = ^{IO_Address[1:0], IO_Address[SEL_LSB-1:5]};

    // Only the selected slave's ready and data are looked at; stray readies
    // from other slaves have no effect.
    always_comb begin
        w_slave_ready = 1'b0;
        w_slave_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_sel == SEL_BITS'(i)) begin
                w_slave_ready = S_Ready[i];
                w_slave_rdata = S_Read_Data[32*i +: 32];
            end
        end
    end

    // Next-state and next-output logic. Outputs are registered, so strobes
    // are set on entry to ISSUE and IO_Ready on exit from RESP.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state     = r_state;
        w_is_read   = r_is_read;
        w_sel       = r_sel;
        w_err       = r_err;
        w_cnt       = r_cnt;
        w_resp_data = r_resp_data;
        w_io_ready  = 1'b0;
        w_io_rdata  = '0;
        w_s_rd_stb  = '0;
        w_s_wr_stb  = '0;
        w_s_addr    = r_s_addr;
        w_s_be      = r_s_be;
        w_s_wdata   = r_s_wdata;
        w_bus_error = 1'b0;
        w_err_count = r_err_count;

        unique case (r_state)
            ST_IDLE: begin
                if (w_request) begin
                    w_is_read = IO_Read_Strobe;   // read wins over write
                    w_sel     = w_cpu_sel;
                    w_s_addr  = IO_Address[4:2];
                    w_s_be    = IO_Byte_Enable;
                    w_s_wdata = IO_Write_Data;
                    if (w_mapped) begin
                        w_state = ST_ISSUE;
                        w_err   = 1'b0;
                        if (IO_Read_Strobe) w_s_rd_stb = w_onehot;
                        else                w_s_wr_stb = w_onehot;
                    end else begin
                        w_state     = ST_RESP;
                        w_err       = 1'b1;
                        w_resp_data = IO_Read_Strobe ? ERR_DATA : 32'h0;
                    end
                end
            end
            ST_ISSUE: begin
                w_state = ST_WAIT;
                w_cnt   = '0;
            end
            ST_WAIT: begin
                w_cnt = r_cnt + 1'b1;
                if (w_slave_ready) begin
                    w_state     = ST_RESP;
                    w_resp_data = r_is_read ? w_slave_rdata : 32'h0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state     = ST_RESP;
                    w_err       = 1'b1;
                    w_resp_data = r_is_read ? ERR_DATA : 32'h0;
                end
            end
            ST_RESP: begin
                w_state     = ST_IDLE;
                w_io_ready  = 1'b1;
                w_io_rdata  = r_resp_data;
                w_bus_error = r_err;
                if (r_err && (r_err_count != 8'hFF)) w_err_count = r_err_count + 8'd1;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            r_state     <= ST_IDLE;
            r_is_read   <= 1'b0;
            r_sel       <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_io_ready  <= 1'b0;
            r_io_rdata  <= '0;
            r_s_rd_stb  <= '0;
            r_s_wr_stb  <= '0;
            r_s_addr    <= '0;
            r_s_be      <= '0;
            r_s_wdata   <= '0;
            r_bus_error <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state;
            r_is_read   <= w_is_read;
            r_sel       <= w_sel;
            r_err       <= w_err;
            r_cnt       <= w_cnt;
            r_resp_data <= w_resp_data;
            r_io_ready  <= w_io_ready;
            r_io_rdata  <= w_io_rdata;
            r_s_rd_stb  <= w_s_rd_stb;
            r_s_wr_stb  <= w_s_wr_stb;
            r_s_addr    <= w_s_addr;
            r_s_be      <= w_s_be;
            r_s_wdata   <= w_s_wdata;
            r_bus_error <= w_bus_error;
            r_err_count <= w_err_count;
        end
    end

    assign IO_Ready       = r_io_ready;
    assign IO_Read_Data   = r_io_rdata;
    assign S_Read_Strobe  = r_s_rd_stb;
    assign S_Write_Strobe = r_s_wr_stb;
    assign S_Address      = r_s_addr;
    assign S_Byte_Enable  = r_s_be;
    assign S_Write_Data   = r_s_wdata;
    assign bus_error      = r_bus_error;
    assign err_count      = r_err_count;

endmodule

// File: tb/tb_mb_io_bus_decoder.sv
// ---------------------------------------------------------------------------
// tb_mb_io_bus_decoder
//
// Directed bench for mb_io_bus_decoder. Each access is described by its CPU
// request and by when the selected slave answers; from those the model works
// out, with latency arithmetic, which cycle each output must show what. A
// per-cycle compare process checks every DUT output against that timeline,
// and each test also pins a few hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_mb_io_bus_decoder;

    localparam int          N_CYC    = 8192;
    localparam logic [31:0] BASE     = 32'hC000_0000;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic         clk;
    logic         reset;
    logic         IO_Addr_Strobe;
    logic         IO_Read_Strobe;
    logic         IO_Write_Strobe;
    logic [31:0]  IO_Address;
    logic [3:0]   IO_Byte_Enable;
    logic [31:0]  IO_Write_Data;
    logic [31:0]  IO_Read_Data;
    logic         IO_Ready;
    logic [3:0]   S_Read_Strobe;
    logic [3:0]   S_Write_Strobe;
    logic [2:0]   S_Address;
    logic [3:0]   S_Byte_Enable;
    logic [31:0]  S_Write_Data;
    logic [127:0] S_Read_Data;
    logic [3:0]   S_Ready;
    logic         bus_error;
    logic [7:0]   err_count;

    mb_io_bus_decoder dut (
        .clk             (clk),
        .reset           (reset),
        .IO_Addr_Strobe  (IO_Addr_Strobe),
        .IO_Read_Strobe  (IO_Read_Strobe),
        .IO_Write_Strobe (IO_Write_Strobe),
        .IO_Address      (IO_Address),
        .IO_Byte_Enable  (IO_Byte_Enable),
        .IO_Write_Data   (IO_Write_Data),
        .IO_Read_Data    (IO_Read_Data),
        .IO_Ready        (IO_Ready),
        .S_Read_Strobe   (S_Read_Strobe),
        .S_Write_Strobe  (S_Write_Strobe),
        .S_Address       (S_Address),
        .S_Byte_Enable   (S_Byte_Enable),
        .S_Write_Data    (S_Write_Data),
        .S_Read_Data     (S_Read_Data),
        .S_Ready         (S_Ready),
        .bus_error       (bus_error),
        .err_count       (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Expected timeline, indexed by cycle; all-zero means "idle outputs".
    bit        exp_ready [N_CYC];
    bit [31:0] exp_rdata [N_CYC];
    bit        exp_berr  [N_CYC];
    bit [3:0]  exp_rd    [N_CYC];
    bit [3:0]  exp_wr    [N_CYC];
    bit        exp_sflag [N_CYC];
    bit [2:0]  exp_saddr [N_CYC];
    bit [3:0]  exp_sbe   [N_CYC];
    bit [31:0] exp_swd   [N_CYC];
    bit        exp_clr   [N_CYC];
    int        m_errcnt = 0;

    // Observations for the literal checks
    int        last_ready_cyc;
    logic [31:0] last_rdata;
    logic [3:0]  last_rd;
    logic [3:0]  last_wr;
    logic [2:0]  last_saddr;

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N_CYC) begin
            if (exp_clr[cyc])                            m_errcnt = 0;
            else if (exp_berr[cyc] && m_errcnt != 255)   m_errcnt = m_errcnt + 1;
            check("io_ready",     IO_Ready,       exp_ready[cyc]);
            check("io_read_data", IO_Read_Data,   exp_rdata[cyc]);
            check("bus_error",    bus_error,      exp_berr[cyc]);
            check("s_read_stb",   S_Read_Strobe,  exp_rd[cyc]);
            check("s_write_stb",  S_Write_Strobe, exp_wr[cyc]);
            check("err_count",    err_count,      m_errcnt);
            if (exp_sflag[cyc] || exp_clr[cyc]) begin
                check("s_address",    S_Address,     exp_saddr[cyc]);
                check("s_byte_en",    S_Byte_Enable, exp_sbe[cyc]);
                check("s_write_data", S_Write_Data,  exp_swd[cyc]);
            end
            if (IO_Ready === 1'b1) begin
                last_ready_cyc = cyc;
                last_rdata     = IO_Read_Data;
            end
            if (|S_Read_Strobe)  begin last_rd = S_Read_Strobe;  last_saddr = S_Address; end
            if (|S_Write_Strobe) begin last_wr = S_Write_Strobe; last_saddr = S_Address; end
        end
    end

    task automatic clear_exp(input int from);
        for (int c = from; c < N_CYC; c++) begin
            exp_ready[c] = 0; exp_rdata[c] = 0; exp_berr[c] = 0;
            exp_rd[c] = 0; exp_wr[c] = 0; exp_sflag[c] = 0;
            exp_saddr[c] = 0; exp_sbe[c] = 0; exp_swd[c] = 0;
        end
    endtask

    // One CPU access. rdy_after: cycles after the slave strobe at which the
    // selected slave raises S_Ready (-1 = never). stray_at/stray_mask: extra
    // S_Ready bits at offset stray_at from the CPU strobe. re_at: offset of a
    // repeated CPU strobe. rst_at: offset at which reset is pulsed (0 = none).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             input int rdy_after, input logic [31:0] sdata,
                             input int stray_at, input logic [3:0] stray_mask,
                             input int re_at, input int rst_at, output int t0);
        logic [1:0]  sel;
        bit          mapped;
        int          done;
        int          rdy_k;
        bit          err;
        logic [31:0] data;
        t0     = cyc;
        sel    = addr[9:8];
        mapped = ((addr >> 10) == (BASE >> 10)) && (sel < 4);
        rdy_k  = -1;
        done   = t0 + 2;
        last_ready_cyc = -1; last_rd = '0; last_wr = '0; last_saddr = '0;
        if (rd || wr) begin
            if (!mapped) begin
                err  = 1;
                data = rd ? ERR_WORD : 32'h0;
            end else begin
                if (rd) exp_rd[t0+1] = 4'(1 << sel);
                else    exp_wr[t0+1] = 4'(1 << sel);
                exp_sflag[t0+1] = 1;
                exp_saddr[t0+1] = addr[4:2];
                exp_sbe[t0+1]   = be;
                exp_swd[t0+1]   = wd;
                // WAIT spans t0+2 .. t0+17; a ready in that span completes
                // two cycles later, otherwise the watchdog finishes at t0+19.
                if (rdy_after >= 1 && rdy_after <= 16) begin
                    rdy_k = 1 + rdy_after;
                    done  = t0 + rdy_k + 2;
                    err   = 0;
                    data  = rd ? sdata : 32'h0;
                end else begin
                    done  = t0 + 19;
                    err   = 1;
                    data  = rd ? ERR_WORD : 32'h0;
                end
            end
            exp_ready[done] = 1;
            exp_rdata[done] = data;
            exp_berr[done]  = err;
        end
        for (int i = 0; i < 4; i++)
            S_Read_Data[32*i +: 32] = (i == int'(sel)) ? sdata : (32'h0BAD_0000 + i);
        IO_Address      = addr;
        IO_Byte_Enable  = be;
        IO_Write_Data   = wd;
        for (int k = 0; k <= done - t0; k++) begin
            IO_Addr_Strobe  = (k == 0) || (re_at != 0 && k == re_at);
            IO_Read_Strobe  = IO_Addr_Strobe ? rd : 1'b0;
            IO_Write_Strobe = IO_Addr_Strobe ? wr : 1'b0;
            S_Ready         = ((k == rdy_k) ? 4'(1 << sel) : 4'b0) |
                              ((stray_at != 0 && k == stray_at) ? stray_mask : 4'b0);
            reset           = (rst_at != 0 && k == rst_at);
            if (reset) begin
                clear_exp(t0 + k + 1);
                exp_clr[t0 + k + 1] = 1;
            end
            @(posedge clk); #1;
        end
        IO_Addr_Strobe = 0; IO_Read_Strobe = 0; IO_Write_Strobe = 0;
        S_Ready = '0; reset = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        reset = 1; IO_Addr_Strobe = 0; IO_Read_Strobe = 0; IO_Write_Strobe = 0;
        IO_Address = '0; IO_Byte_Enable = '0; IO_Write_Data = '0;
        S_Read_Data = '0; S_Ready = '0;
        last_ready_cyc = -1; last_rdata = '0; last_rd = '0; last_wr = '0; last_saddr = '0;
        exp_clr[1] = 1; exp_clr[2] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        // 1: write to slave 1
        do_access(0, 1, 32'hC000_0104, 4'hF, 32'h1234_5678, 1, 32'h0, 0, 4'b0, 0, 0, t0);
        check("t1_wr_stb",  last_wr, 4'b0010);
        check("t1_saddr",   last_saddr, 3'h1);
        check("t1_latency", last_ready_cyc - t0, 4);
        check("t1_errcnt",  err_count, 0);

        // 2: read from slave 3
        do_access(1, 0, 32'hC000_0308, 4'hF, 32'h0, 1, 32'hA5A5_0001, 0, 4'b0, 0, 0, t0);
        check("t2_rd_stb", last_rd, 4'b1000);
        check("t2_saddr",  last_saddr, 3'h2);
        check("t2_rdata",  last_rdata, 32'hA5A5_0001);

        // 3: wrong base
        do_access(1, 0, 32'h8000_0000, 4'hF, 32'h0, 1, 32'h0, 0, 4'b0, 0, 0, t0);
        check("t3_no_stb",  last_rd, 4'b0000);
        check("t3_latency", last_ready_cyc - t0, 2);
        check("t3_rdata",   last_rdata, 32'hDEAD_BEEF);
        check("t3_errcnt",  err_count, 1);

        // 4: hung slave 0, late ready during the response cycle
        do_access(1, 0, 32'hC000_0000, 4'hF, 32'h0, -1, 32'h1111_2222, 18, 4'b0001, 0, 0, t0);
        check("t4_latency", last_ready_cyc - t0, 19);
        check("t4_rdata",   last_rdata, 32'hDEAD_BEEF);
        check("t4_errcnt",  err_count, 2);

        // 5: stray ready from slave 2 and a second CPU strobe during WAIT
        do_access(1, 0, 32'hC000_0000, 4'hF, 32'h0, 6, 32'h5555_AAAA, 3, 4'b0100, 4, 0, t0);
        check("t5_latency", last_ready_cyc - t0, 9);
        check("t5_rdata",   last_rdata, 32'h5555_AAAA);

        // both strobes set: read wins
        do_access(1, 1, 32'hC000_0204, 4'h3, 32'hFFFF_0000, 2, 32'h0000_C0DE, 0, 4'b0, 0, 0, t0);
        check("rw_rd_stb", last_rd, 4'b0100);
        check("rw_wr_stb", last_wr, 4'b0000);
        check("rw_rdata",  last_rdata, 32'h0000_C0DE);

        // write to a hung slave: error completion with zero data
        do_access(0, 1, 32'hC000_0100, 4'hC, 32'h0000_0042, -1, 32'h0, 0, 4'b0, 0, 0, t0);
        check("wto_rdata",  last_rdata, 32'h0);
        check("wto_errcnt", err_count, 3);

        // address strobe alone is ignored
        do_access(0, 0, 32'hC000_0100, 4'hF, 32'h0, -1, 32'h0, 0, 4'b0, 0, 0, t0);
        check("nostb_ready", last_ready_cyc, -1);

        // 6: reset while waiting aborts the access, then a normal read
        do_access(1, 0, 32'hC000_0000, 4'hF, 32'h0, -1, 32'h0, 0, 4'b0, 0, 5, t0);
        check("rst_no_ready", last_ready_cyc, -1);
        check("rst_errcnt",   err_count, 0);
        do_access(1, 0, 32'hC000_020C, 4'hF, 32'h0, 3, 32'h0BEE_F123, 0, 4'b0, 0, 0, t0);
        check("post_rst_latency", last_ready_cyc - t0, 6);
        check("post_rst_rdata",   last_rdata, 32'h0BEE_F123);

        // saturation of the error counter
        for (int i = 0; i < 300; i++)
            do_access(i[0], ~i[0], 32'h4000_0000 + 32'(i * 4), 4'hF, 32'(i), 1, 32'h0,
                      0, 4'b0, 0, 0, t0);
        check("sat_errcnt", err_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
